// File: rtl/ram_seq_pkg.sv
// Shared types and limits for the ram_seq memory block.
// Holds the controller state encoding and the read-latency legality check.
package ram_seq_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam int MAX_READ_LATENCY = 4;

  function automatic bit read_latency_ok(input int latency);
    return (latency >= 1) && (latency <= MAX_READ_LATENCY);
  endfunction

endpackage

// File: rtl/ram_seq_core.sv
// Bare single-port synchronous array with one write port and a registered read port.
// The array itself is never reset so it maps onto block RAM.
module ram_seq_core #(
  parameter int AddressSize = 16,
  parameter int DataSize    = 8
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   write_en,
  input  logic                   read_en,
  input  logic [AddressSize-1:0] addr,
  input  logic [DataSize-1:0]    wdata,
  output logic [DataSize-1:0]    rdata
);

  logic [DataSize-1:0] mem [2**AddressSize];

  always_ff @(posedge Clk) begin
    if (write_en) begin
      mem[addr] <= wdata;
    end
  end

  // Only the output register is reset, matching the block RAM output-register reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      rdata <= '0;
    end else if (read_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_seq.sv
// Single-port RAM with request/ready handshake, optional post-reset zero fill
// and a configurable registered read latency.
module ram_seq
  import ram_seq_pkg::*;
#(
  parameter int AddressSize  = 16,
  parameter int DataSize     = 8,
  parameter int ReadLatency  = 1,
  parameter int ClearOnReset = 1
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   Req,
  input  logic                   WE_n,
  input  logic [AddressSize-1:0] Address,
  input  logic [DataSize-1:0]    WData,
  output logic                   Ready,
  output logic                   Busy,
  output logic [DataSize-1:0]    RData,
  output logic                   RValid
);

  if (!read_latency_ok(ReadLatency)) begin : g_bad_latency
    $error("ram_seq: ReadLatency must be in 1..%0d", MAX_READ_LATENCY);
  end

  // Extra counter bit keeps the terminal compare distinct from address 0 after wrap.
  localparam logic [AddressSize:0] CLR_LAST    = {1'b0, {AddressSize{1'b1}}};
  localparam state_e               RESET_STATE = (ClearOnReset != 0) ? CLEAR : IDLE;

  state_e                 state_reg, state_next;
  logic [AddressSize:0]   clr_cnt_reg, clr_cnt_next;
  logic                   rst_done_reg;
  logic [ReadLatency-1:0] valid_reg;

  logic                   mem_we;
  logic                   mem_re;
  logic [AddressSize-1:0] mem_addr;
  logic [DataSize-1:0]    mem_wdata;
  logic [DataSize-1:0]    core_rdata;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_reg    <= RESET_STATE;
      clr_cnt_reg  <= '0;
      rst_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clr_cnt_reg  <= clr_cnt_next;
      rst_done_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    if (state_reg == CLEAR) begin
      clr_cnt_next = clr_cnt_reg + (AddressSize+1)'(1);
      if (clr_cnt_reg == CLR_LAST) begin
        state_next = IDLE;
      end
    end
  end

  // Reset always wins over a request presented at the same edge.
  always_comb begin
    Ready     = 1'b0;
    Busy      = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = Address;
    mem_wdata = WData;
    case (state_reg)
      CLEAR: begin
        Busy      = 1'b1;
        mem_we    = Rst_n;
        mem_addr  = clr_cnt_reg[AddressSize-1:0];
        mem_wdata = '0;
      end
      IDLE: begin
        Ready  = rst_done_reg;
        mem_we = Rst_n & rst_done_reg & Req & ~WE_n;
        mem_re = Rst_n & rst_done_reg & Req & WE_n;
      end
      default: ;
    endcase
  end

  ram_seq_core #(
    .AddressSize(AddressSize),
    .DataSize   (DataSize)
  ) u_core (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .write_en(mem_we),
    .read_en (mem_re),
    .addr    (mem_addr),
    .wdata   (mem_wdata),
    .rdata   (core_rdata)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      valid_reg <= '0;
    end else begin
      valid_reg[0] <= mem_re;
      for (int k = 1; k < ReadLatency; k++) begin
        valid_reg[k] <= valid_reg[k-1];
      end
    end
  end

  assign RValid = valid_reg[ReadLatency-1];

  if (ReadLatency == 1) begin : g_direct
    assign RData = core_rdata;
  end else begin : g_pipe
    // Stages load only on a valid beat, so RData holds the last delivered word.
    logic [DataSize-1:0] data_reg [ReadLatency-1];

    always_ff @(posedge Clk) begin
      if (!Rst_n) begin
        for (int k = 0; k < ReadLatency - 1; k++) begin
          data_reg[k] <= '0;
        end
      end else begin
        if (valid_reg[0]) begin
          data_reg[0] <= core_rdata;
        end
        for (int k = 1; k < ReadLatency - 1; k++) begin
          if (valid_reg[k]) begin
            data_reg[k] <= data_reg[k-1];
          end
        end
      end
    end

    assign RData = data_reg[ReadLatency-2];
  end

endmodule

// File: tb/tb_ram_seq.sv
// Directed bench for ram_seq: instance A (ReadLatency=3, clear on reset) and
// instance B (ReadLatency=1, no clear), sampled on the falling clock edge.
module tb_ram_seq;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic       rst_n_a, req_a, we_n_a, ready_a, busy_a, rvalid_a;
  logic [3:0] addr_a;
  logic [7:0] wdata_a, rdata_a;
  logic       rst_n_b, req_b, we_n_b, ready_b, busy_b, rvalid_b;
  logic [3:0] addr_b;
  logic [7:0] wdata_b, rdata_b;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [3:0] rd_addr [16];
  logic [7:0] rd_exp  [16];

  ram_seq #(.AddressSize(4), .DataSize(8), .ReadLatency(3), .ClearOnReset(1)) u_dut_a (
    .Clk(clk), .Rst_n(rst_n_a), .Req(req_a), .WE_n(we_n_a), .Address(addr_a),
    .WData(wdata_a), .Ready(ready_a), .Busy(busy_a), .RData(rdata_a), .RValid(rvalid_a)
  );

  ram_seq #(.AddressSize(4), .DataSize(8), .ReadLatency(1), .ClearOnReset(0)) u_dut_b (
    .Clk(clk), .Rst_n(rst_n_b), .Req(req_b), .WE_n(we_n_b), .Address(addr_b),
    .WData(wdata_b), .Ready(ready_b), .Busy(busy_b), .RData(rdata_b), .RValid(rvalid_b)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic req, input logic we_n,
                       input logic [3:0] addr, input logic [7:0] wdata);
    if (sel == 0) begin
      req_a = req; we_n_a = we_n; addr_a = addr; wdata_a = wdata;
    end else begin
      req_b = req; we_n_b = we_n; addr_b = addr; wdata_b = wdata;
    end
  endtask

  task automatic write_word(input int sel, input logic [3:0] addr, input logic [7:0] data);
    @(negedge clk);
    drive(sel, 1'b1, 1'b0, addr, data);
  endtask

  task automatic idle(input int sel);
    @(negedge clk);
    drive(sel, 1'b0, 1'b1, 4'h0, 8'h00);
  endtask

  // Back-to-back reads of rd_addr[0..n-1]; every cycle checks RValid, and RData on valid beats.
  task automatic read_seq(input int sel, input int n, input string tag);
    int   lat;
    logic exp_v, obs_v;
    lat = (sel == 0) ? 3 : 1;
    for (int c = 0; c < n + lat + 1; c++) begin
      @(negedge clk);
      exp_v = (c >= lat) && (c - lat < n);
      obs_v = (sel == 0) ? rvalid_a : rvalid_b;
      check({tag, " rvalid"}, 32'(obs_v), 32'(exp_v));
      if (exp_v) begin
        check({tag, " rdata"}, 32'((sel == 0) ? rdata_a : rdata_b), 32'(rd_exp[c-lat]));
      end
      if (c < n) drive(sel, 1'b1, 1'b1, rd_addr[c], 8'h00);
      else       drive(sel, 1'b0, 1'b1, 4'h0, 8'h00);
    end
  endtask

  // Counts not-ready cycles from the current falling edge; bounded at 64.
  task automatic wait_ready_a(output int cycles);
    cycles = 0;
    for (int i = 0; i < 64 && !ready_a; i++) begin
      check("clear busy", 32'(busy_a), 32'd1);
      check("clear rvalid", 32'(rvalid_a), 32'd0);
      cycles++;
      @(negedge clk);
    end
    drive(0, 1'b0, 1'b1, 4'h0, 8'h00);
  endtask

  initial begin
    int cycles;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    drive(0, 1'b0, 1'b1, 4'h0, 8'h00);
    drive(1, 1'b0, 1'b1, 4'h0, 8'h00);

    // Reset values
    @(negedge clk);
    check("rst A busy", 32'(busy_a), 32'd1);
    check("rst A ready", 32'(ready_a), 32'd0);
    check("rst A rvalid", 32'(rvalid_a), 32'd0);
    check("rst A rdata", 32'(rdata_a), 32'h00);
    check("rst B busy", 32'(busy_b), 32'd0);
    check("rst B ready", 32'(ready_b), 32'd0);
    check("rst B rvalid", 32'(rvalid_b), 32'd0);
    check("rst B rdata", 32'(rdata_b), 32'h00);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    @(negedge clk);
    check("B ready after release", 32'(ready_b), 32'd1);
    check("B busy after release", 32'(busy_b), 32'd0);

    // Read-after-write, latency 1
    write_word(1, 4'h3, 8'hA5);
    rd_addr[0] = 4'h3; rd_exp[0] = 8'hA5;
    read_seq(1, 1, "raw lat1");

    // No clear on reset: contents survive
    write_word(1, 4'h7, 8'h5A);
    idle(1);
    rst_n_b = 1'b0;
    @(negedge clk);
    check("B rst ready", 32'(ready_b), 32'd0);
    check("B rst rvalid", 32'(rvalid_b), 32'd0);
    check("B rst rdata", 32'(rdata_b), 32'h00);
    rst_n_b = 1'b1;
    @(negedge clk);
    check("B ready first cycle", 32'(ready_b), 32'd1);
    rd_addr[0] = 4'h7; rd_exp[0] = 8'h5A;
    read_seq(1, 1, "B keep");
    check("B rdata hold", 32'(rdata_b), 32'h5A);

    // Finish A's initial clear, then preset every word to 0xFF
    wait_ready_a(cycles);
    check("A first clear done", 32'(ready_a), 32'd1);
    for (int i = 0; i < 16; i++) write_word(0, 4'(i), 8'hFF);

    // Reset with a write request held through the whole clear window
    @(negedge clk);
    rst_n_a = 1'b0;
    drive(0, 1'b1, 1'b0, 4'h5, 8'h77);
    @(negedge clk);
    rst_n_a = 1'b1;
    check("A rst2 ready", 32'(ready_a), 32'd0);
    wait_ready_a(cycles);
    check("A clear cycles", 32'(cycles), 32'd16);
    check("A busy after clear", 32'(busy_a), 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd_addr[i] = 4'(i);
      rd_exp[i]  = 8'h00;
    end
    read_seq(0, 16, "A cleared");

    // Latency 3, back-to-back reads in order
    write_word(0, 4'h0, 8'h10);
    write_word(0, 4'h1, 8'h11);
    write_word(0, 4'h2, 8'h12);
    rd_addr[0] = 4'h0; rd_exp[0] = 8'h10;
    rd_addr[1] = 4'h1; rd_exp[1] = 8'h11;
    rd_addr[2] = 4'h2; rd_exp[2] = 8'h12;
    read_seq(0, 3, "A lat3");
    check("A rdata hold", 32'(rdata_a), 32'h12);

    // Reset one cycle after a read accept drops the response and restarts clear
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 4'h1, 8'h00);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 4'h0, 8'h00);
    rst_n_a = 1'b0;
    @(negedge clk);
    rst_n_a = 1'b1;
    check("A rst3 rdata", 32'(rdata_a), 32'h00);
    check("A rst3 ready", 32'(ready_a), 32'd0);
    wait_ready_a(cycles);
    check("A restart clear cycles", 32'(cycles), 32'd16);
    rd_addr[0] = 4'h1; rd_exp[0] = 8'h00;
    read_seq(0, 1, "A restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
